// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
// Holds the run-controller state encodings, the exit-syscall code and the
// default datapath widths used by run_ctrl and related units.
package mips_pkg;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        HALT  = 2'd3
    } run_state_t;

    // v0 value that requests program termination
    localparam logic [31:0] SYSCALL_EXIT = 32'ha;

    localparam int DATA_WIDTH_DEF   = 32;
    localparam int SYSCNT_WIDTH_DEF = 8;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a synchronous level input.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   d    - synchronous level input
//   rise - one-cycle pulse while d is high and was low the previous cycle
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/run_ctrl.sv
// Run controller for the 5-stage MIPS pipeline.
// Produces the single pipeline enable (pipeline registers, PC, LO and the
// data-memory write strobe) and sequences free-run, single-step, breakpoint
// pause and exit-syscall halt. Also latches a0 on display syscalls for the
// LED unit and counts enabled cycles.
//
// Optional feature macro: RUN_CTRL_BP_EN
//   defined   - breakpoint comparator, resume-skip and bp_hit present
//   undefined - no breakpoint; bp_en/bp_addr/pc are ignored, bp_hit tied 0
//
// Ports:
//   clk, rst (async active-low)
//   en        - run switch (level)
//   step      - single-step button (synchronous level, rising edge acts)
//   halt_req  - WB-stage exit syscall
//   disp_req  - WB-stage display syscall
//   pc        - IF-stage PC
//   bp_en, bp_addr - breakpoint enable / address
//   a0_data   - $a0 value
//   pipe_en   - pipeline enable (combinational)
//   halted    - controller is in HALT
//   bp_hit    - last pause came from the breakpoint
//   led_data  - a0 captured at the last display syscall
//   sys_count - display syscalls retired (wraps)
//   cycle_count - enabled cycles (wraps)
module run_ctrl
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int SYSCNT_WIDTH = SYSCNT_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    step,
    input  logic                    halt_req,
    input  logic                    disp_req,
    input  logic [DATA_WIDTH-1:0]   pc,
    input  logic                    bp_en,
    input  logic [DATA_WIDTH-1:0]   bp_addr,
    input  logic [DATA_WIDTH-1:0]   a0_data,
    output logic                    pipe_en,
    output logic                    halted,
    output logic                    bp_hit,
    output logic [DATA_WIDTH-1:0]   led_data,
    output logic [SYSCNT_WIDTH-1:0] sys_count,
    output logic [DATA_WIDTH-1:0]   cycle_count
);

    run_state_t state, next_state;
    logic       step_rise;
    logic       bp_match;

    edge_detect u_step_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (step),
        .rise (step_rise)
    );

`ifdef RUN_CTRL_BP_EN
    // skip masks the comparator for the first enabled cycle after leaving
    // PAUSE so that resuming at bp_addr fetches it instead of re-triggering.
    logic skip;
    logic leave_pause;

    assign bp_match    = bp_en & (pc == bp_addr) & ~skip;
    assign leave_pause = (state == PAUSE) & (next_state != PAUSE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skip   <= 1'b0;
            bp_hit <= 1'b0;
        end else begin
            if (leave_pause) begin
                skip <= 1'b1;
            end else if (pipe_en) begin
                skip <= 1'b0;
            end

            if ((state == RUN) & ~halt_req & bp_match) begin
                bp_hit <= 1'b1;
            end else if (leave_pause) begin
                bp_hit <= 1'b0;
            end
        end
    end
`else
    logic unused_bp;

    assign bp_match  = 1'b0;
    assign bp_hit    = 1'b0;
    assign unused_bp = ^{bp_en, bp_addr, pc};
`endif

    // Enable drops in the same cycle as an exit syscall or breakpoint so the
    // syscall stays in WB and a pending store does not commit.
    assign pipe_en = ((state == RUN) | (state == STEP)) & ~halt_req
                   & ~((state == RUN) & bp_match);
    assign halted  = (state == HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= PAUSE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            PAUSE: begin
                if (en) begin
                    next_state = RUN;
                end else if (step_rise) begin
                    next_state = STEP;
                end
            end
            RUN: begin
                if (halt_req) begin
                    next_state = HALT;
                end else if (bp_match) begin
                    next_state = PAUSE;
                end else if (!en) begin
                    next_state = PAUSE;
                end
            end
            STEP: begin
                next_state = halt_req ? HALT : PAUSE;
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = PAUSE;
            end
        endcase
    end

    // pipe_en already excludes halt_req, so a simultaneous halt/display
    // request never updates the LED latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_data    <= '0;
            sys_count   <= '0;
            cycle_count <= '0;
        end else begin
            if (pipe_en) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (disp_req & pipe_en) begin
                led_data  <= a0_data;
                sys_count <= sys_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        step;
    logic        halt_req;
    logic        disp_req;
    logic [31:0] pc;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] a0_data;
    logic        pipe_en;
    logic        halted;
    logic        bp_hit;
    logic [31:0] led_data;
    logic [7:0]  sys_count;
    logic [31:0] cycle_count;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef RUN_CTRL_BP_EN
    localparam bit BP_ON = 1'b1;
`else
    localparam bit BP_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    run_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .step        (step),
        .halt_req    (halt_req),
        .disp_req    (disp_req),
        .pc          (pc),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .a0_data     (a0_data),
        .pipe_en     (pipe_en),
        .halted      (halted),
        .bp_hit      (bp_hit),
        .led_data    (led_data),
        .sys_count   (sys_count),
        .cycle_count (cycle_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 paused, 1 running, 2 single step, 3 halted
    int          m_mode, n_mode;
    bit          m_skip, n_skip;
    bit          m_hit, n_hit;
    bit          m_stepq, n_stepq;
    logic [31:0] m_led, n_led;
    logic [7:0]  m_sys, n_sys;
    logic [31:0] m_cyc, n_cyc;
    bit          n_valid = 1'b0;
    bit          rise_m, brk_m, pe_m;

    always @(negedge clk) begin
        if (!rst) begin
            m_mode = 0; m_skip = 0; m_hit = 0; m_stepq = 0;
            m_led = 0; m_sys = 0; m_cyc = 0;
        end
        rise_m = step && !m_stepq;
        brk_m  = BP_ON && bp_en && (pc == bp_addr) && !m_skip;
        pe_m   = rst && (m_mode == 1 || m_mode == 2) && !halt_req && !(m_mode == 1 && brk_m);

        check("pipe_en", pipe_en, pe_m);
        check("halted", halted, m_mode == 3);
        check("bp_hit", bp_hit, m_hit);
        check("led_data", led_data, m_led);
        check("sys_count", sys_count, m_sys);
        check("cycle_count", cycle_count, m_cyc);

        n_valid = 1'b0;
        if (rst) begin
            n_mode = m_mode; n_hit = m_hit; n_skip = m_skip;
            case (m_mode)
                0: if (en) n_mode = 1; else if (rise_m) n_mode = 2;
                1: if (halt_req) n_mode = 3;
                   else if (brk_m) begin n_mode = 0; n_hit = 1; end
                   else if (!en) n_mode = 0;
                2: n_mode = halt_req ? 3 : 0;
                default: n_mode = 3;
            endcase
            if (m_mode == 0 && n_mode != 0) begin
                n_hit = 0;
                n_skip = 1;
            end else if (pe_m) begin
                n_skip = 0;
            end
            n_stepq = step;
            n_cyc   = m_cyc + (pe_m ? 32'd1 : 32'd0);
            n_led   = m_led;
            n_sys   = m_sys;
            if (pe_m && disp_req) begin
                n_led = a0_data;
                n_sys = m_sys + 8'd1;
            end
            n_valid = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (n_valid && rst) begin
            m_mode = n_mode; m_skip = n_skip; m_hit = n_hit; m_stepq = n_stepq;
            m_led = n_led; m_sys = n_sys; m_cyc = n_cyc;
        end
        n_valid = 1'b0;
    end

    // ---------------- stimulus ----------------
    bit found;

    initial begin
        rst = 1'b0; en = 1'b0; step = 1'b0; halt_req = 1'b0; disp_req = 1'b0;
        pc = 32'h0; bp_en = 1'b0; bp_addr = 32'h0; a0_data = 32'h0;
        cyc(2);
        rst = 1'b1;
        cyc(1);

        // free run for seven cycles, then exit syscall
        en = 1'b1;
        cyc(1);
        check("run_first_pe", pipe_en, 1);
        cyc(7);
        halt_req = 1'b1;
        #1;
        check("halt_same_cycle_pe", pipe_en, 0);
        cyc(1);
        halt_req = 1'b0;
        check("halted_after_exit", halted, 1);
        check("run_cycle_count", cycle_count, 7);

        // HALT ignores en and step
        en = 1'b0; cyc(1);
        en = 1'b1; step = 1'b1; cyc(2);
        step = 1'b0; en = 1'b0;
        check("halt_no_pe", pipe_en, 0);
        check("halt_count_frozen", cycle_count, 7);

        rst = 1'b0;
        #1;
        check("rst_pipe_en", pipe_en, 0);
        check("rst_halted", halted, 0);
        check("rst_cycle_count", cycle_count, 0);
        cyc(1);
        rst = 1'b1;
        cyc(1);

        // held step gives exactly one enabled cycle
        step = 1'b1; cyc(5);
        step = 1'b0; cyc(2);
        check("step_held_count", cycle_count, 1);
        step = 1'b1; cyc(1);
        step = 1'b0; cyc(2);
        check("step_second_count", cycle_count, 2);

        // display syscall while running, then while paused, then with halt
        en = 1'b1; cyc(2);
        a0_data = 32'h1234; disp_req = 1'b1; cyc(1);
        disp_req = 1'b0;
        check("disp_led", led_data, 32'h1234);
        check("disp_count", sys_count, 1);
        en = 1'b0; cyc(2);
        a0_data = 32'h5678; disp_req = 1'b1; cyc(1);
        disp_req = 1'b0;
        check("disp_paused_led", led_data, 32'h1234);
        check("disp_paused_count", sys_count, 1);
        en = 1'b1; cyc(2);
        a0_data = 32'h9999; disp_req = 1'b1; halt_req = 1'b1; cyc(1);
        disp_req = 1'b0; halt_req = 1'b0; en = 1'b0;
        check("both_req_led", led_data, 32'h1234);
        check("both_req_halted", halted, 1);

        rst = 1'b0; cyc(1);
        rst = 1'b1; cyc(1);

        // breakpoint at 0x20
        bp_en = 1'b1; bp_addr = 32'h20; pc = 32'h0; en = 1'b1;
        cyc(1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            pc = pc + 32'd4;
            #1;
            if (pc == 32'h20) found = 1'b1;
            else cyc(1);
        end
        check("bp_pc_reached", found, 1);
        check("bp_cycle_pe", pipe_en, !BP_ON);
        cyc(1);
        check("bp_hit_set", bp_hit, BP_ON);
        en = 1'b0; cyc(1);
        check("bp_paused_pe", pipe_en, 0);
        check("bp_hit_held", bp_hit, BP_ON);
        en = 1'b1; cyc(1);
        check("bp_resume_pe", pipe_en, 1);
        check("bp_hit_cleared", bp_hit, 0);
        cyc(1);
        pc = 32'h24; #1;
        check("bp_continue_pe", pipe_en, 1);
        en = 1'b0; cyc(2);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 3) == 0) step = ~step;
            halt_req = ($urandom_range(0, 79) == 0);
            disp_req = ($urandom_range(0, 5) == 0);
            pc       = 32'($urandom_range(0, 7)) * 32'd4;
            bp_en    = $urandom_range(0, 1) == 1;
            bp_addr  = 32'($urandom_range(0, 7)) * 32'd4;
            a0_data  = $urandom;
            rst      = ($urandom_range(0, 149) != 0);
            cyc(1);
        end
        rst = 1'b1;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
